// File: rtl/wasm_immediate_fetch_pkg.sv
// Shared definitions for the immediate fetch unit: immediate kind codes,
// byte limits per kind and the FSM state encoding.
package wasm_immediate_fetch_pkg;

    // Immediate kind codes as presented on i_kind; 6 and 7 are illegal.
    localparam logic [2:0] IMM_FIX32  = 3'd0;
    localparam logic [2:0] IMM_FIX64  = 3'd1;
    localparam logic [2:0] IMM_ULEB32 = 3'd2;
    localparam logic [2:0] IMM_SLEB32 = 3'd3;
    localparam logic [2:0] IMM_ULEB64 = 3'd4;
    localparam logic [2:0] IMM_SLEB64 = 3'd5;

    // Byte counts: fixed widths and maximum LEB128 encodings.
    localparam logic [3:0] FIX32_BYTES     = 4'd4;
    localparam logic [3:0] FIX64_BYTES     = 4'd8;
    localparam logic [3:0] LEB32_MAX_BYTES = 4'd5;
    localparam logic [3:0] LEB64_MAX_BYTES = 4'd10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StAccum = 2'd2,
        StDone  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/leb128_sign_extend.sv
// Sign-extends an accumulated LEB128 payload.
//   i_raw    : payload bits assembled 7 per byte, byte 0 in bits [6:0]
//   i_count  : number of bytes consumed (1..10)
//   i_is64   : 1 = extend to bit 63, 0 = extend to bit 31 and clear [63:32]
//   o_value  : sign-extended result
// Purely combinational; also used by the decoder for block-type immediates.
module leb128_sign_extend (
    input  logic [63:0] i_raw,
    input  logic [3:0]  i_count,
    input  logic        i_is64,
    output logic [63:0] o_value
);

    logic [6:0] w_msb;
    logic [6:0] w_width;
    logic       w_extend;
    logic       w_sign;

    always_comb begin
        // Sign bit sits at 7n-1; count 0 wraps to 127 and disables extension.
        w_msb    = ({3'b000, i_count} << 3) - {3'b000, i_count} - 7'd1;
        w_width  = i_is64 ? 7'd64 : 7'd32;
        // If the encoding already covers the full width there is nothing to extend.
        w_extend = (w_msb < (w_width - 7'd1));
        w_sign   = w_extend ? i_raw[w_msb[5:0]] : 1'b0;
        o_value  = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(w_width)) begin
                if (w_extend && (i > int'(w_msb))) begin
                    o_value[i] = w_sign;
                end else begin
                    o_value[i] = i_raw[i];
                end
            end
        end
    end

endmodule

// File: rtl/wasm_immediate_fetch.sv
// Walks program ROM bytes and assembles a fixed-width or LEB128 immediate.
//   i_clk/i_rst_n  : clock, asynchronous active-low reset
//   i_start        : begin fetch (sampled only when idle) with i_kind, i_start_addr
//   o_rom_addr     : ROM byte address; i_rom_data returns it one cycle later
//   o_busy         : fetch in progress
//   o_done         : one-cycle pulse; o_value, o_next_addr, o_malformed valid
//   o_value        : assembled 64-bit immediate
//   o_next_addr    : start address plus bytes consumed
//   o_malformed    : overlong LEB128 or illegal kind
module wasm_immediate_fetch
    import wasm_immediate_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [2:0]            i_kind,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [7:0]            i_rom_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [63:0]           o_value,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_malformed
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    fetch_state_e          r_state, w_state_next;
    logic [2:0]            r_kind;
    logic [ADDR_WIDTH-1:0] r_start_addr;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [3:0]            r_cnt;
    logic [63:0]           r_acc;
    logic [63:0]           r_value;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic                  r_malformed;

    logic        w_legal, w_is_fix, w_is64, w_signed, w_uleb32;
    logic [3:0]  w_limit, w_count;
    logic        w_last_byte, w_term, w_overlong;
    logic [6:0]  w_shift8, w_shift7;
    logic [63:0] w_acc_next, w_sext, w_final;

    always_comb begin
        w_legal  = (r_kind <= IMM_SLEB64);
        w_is_fix = (r_kind == IMM_FIX32) || (r_kind == IMM_FIX64);
        w_is64   = (r_kind == IMM_FIX64) || (r_kind == IMM_ULEB64) || (r_kind == IMM_SLEB64);
        w_signed = (r_kind == IMM_SLEB32) || (r_kind == IMM_SLEB64);
        w_uleb32 = (r_kind == IMM_ULEB32);
        if (w_is_fix) begin
            w_limit = w_is64 ? FIX64_BYTES : FIX32_BYTES;
        end else begin
            w_limit = w_is64 ? LEB64_MAX_BYTES : LEB32_MAX_BYTES;
        end
        w_count     = r_cnt + 4'd1;
        w_last_byte = (w_count == w_limit);
        w_term      = w_is_fix ? w_last_byte : (!i_rom_data[7] || w_last_byte);
        w_overlong  = !w_is_fix && i_rom_data[7] && w_last_byte;
        w_shift8    = {r_cnt, 3'b000};
        w_shift7    = w_shift8 - {3'b000, r_cnt};
        // Payload bits shifted past bit 63 (10th LEB byte) are dropped unchecked.
        if (w_is_fix) begin
            w_acc_next = r_acc | ({56'd0, i_rom_data} << w_shift8);
        end else begin
            w_acc_next = r_acc | ({57'd0, i_rom_data[6:0]} << w_shift7);
        end
    end

    leb128_sign_extend u_sign_extend (
        .i_raw   (w_acc_next),
        .i_count (w_count),
        .i_is64  (w_is64),
        .o_value (w_sext)
    );

    always_comb begin
        if (w_overlong) begin
            w_final = '0;
        end else if (w_is_fix) begin
            w_final = w_acc_next;
        end else if (w_signed) begin
            w_final = w_sext;
        end else if (w_uleb32) begin
            w_final = {32'd0, w_acc_next[31:0]};
        end else begin
            w_final = w_acc_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StPrime;
            StPrime: w_state_next = w_legal ? StAccum : StDone;
            StAccum: if (w_term) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kind       <= '0;
            r_start_addr <= '0;
            r_rom_addr   <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_value      <= '0;
            r_next_addr  <= '0;
            r_malformed  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_kind       <= i_kind;
                        r_start_addr <= i_start_addr;
                        r_rom_addr   <= i_start_addr;
                        r_cnt        <= '0;
                        r_acc        <= '0;
                    end
                end
                StPrime: begin
                    r_rom_addr <= r_rom_addr + ADDR_ONE;
                    if (!w_legal) begin
                        r_value     <= '0;
                        r_malformed <= 1'b1;
                        r_next_addr <= r_start_addr;
                    end
                end
                StAccum: begin
                    // Address runs one byte ahead; the extra read is simply discarded.
                    r_rom_addr <= r_rom_addr + ADDR_ONE;
                    r_cnt      <= w_count;
                    r_acc      <= w_acc_next;
                    if (w_term) begin
                        r_value     <= w_final;
                        r_malformed <= w_overlong;
                        r_next_addr <= r_start_addr + {{(ADDR_WIDTH-4){1'b0}}, w_count};
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_busy      = (r_state == StPrime) || (r_state == StAccum);
    assign o_done      = (r_state == StDone);
    assign o_value     = r_value;
    assign o_next_addr = r_next_addr;
    assign o_malformed = r_malformed;

endmodule

// File: tb/tb_wasm_immediate_fetch.sv
module tb_wasm_immediate_fetch;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    kind = '0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = '0;
    logic          busy, done, malformed;
    logic [63:0]   value;
    logic [AW-1:0] next_addr;

    wasm_immediate_fetch #(.ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_kind       (kind),
        .i_start_addr (start_addr),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_value      (value),
        .o_next_addr  (next_addr),
        .o_malformed  (malformed)
    );

    always #5 clk = ~clk;

    // 256-byte ROM image aliased over the whole address space.
    logic [7:0] mem [256];
    always @(posedge clk) rom_data <= mem[rom_addr[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0]   value;
        logic [AW-1:0] next;
        logic          mal;
        int            lat;
        int            issue;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending fetch (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("value", value, e.value);
                chk("next_addr", 64'(next_addr), 64'(e.next));
                chk("malformed", 64'(malformed), 64'(e.mal));
                chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    function automatic logic [7:0] rd(input logic [AW-1:0] a, input int i);
        logic [AW-1:0] x;
        x = a + AW'(i);
        return mem[x[7:0]];
    endfunction

    // Reference model computed directly from the encoding rules.
    function automatic exp_t model(input logic [2:0] k, input logic [AW-1:0] a);
        exp_t          e;
        logic [127:0]  acc;
        logic [127:0]  one;
        logic [7:0]    b;
        int            n, lim, w;
        bit            sgn;
        e.issue = 0;
        e.mal   = 1'b0;
        acc     = '0;
        one     = 128'd1;
        if (k > 3'd5) begin
            e.value = '0; e.next = a; e.mal = 1'b1; e.lat = 1;
            return e;
        end
        if (k <= 3'd1) begin
            n = (k == 3'd0) ? 4 : 8;
            for (int i = 0; i < n; i++) acc = acc + (128'(rd(a, i)) << (8 * i));
            e.value = acc[63:0];
            e.next  = a + AW'(n);
            e.lat   = n + 1;
            return e;
        end
        lim = (k < 3'd4) ? 5 : 10;
        w   = (k < 3'd4) ? 32 : 64;
        sgn = (k == 3'd3) || (k == 3'd5);
        n   = 0;
        for (int i = 0; i < lim; i++) begin
            b   = rd(a, i);
            acc = acc + (128'(b[6:0]) << (7 * i));
            n   = i + 1;
            if (!b[7]) break;
            if (i == lim - 1) e.mal = 1'b1;
        end
        if (sgn && (7 * n < w) && acc[7 * n - 1]) acc = acc - (one << (7 * n));
        if (e.mal) e.value = '0;
        else if (w == 32) e.value = {32'd0, acc[31:0]};
        else e.value = acc[63:0];
        e.next = a + AW'(n);
        e.lat  = n + 1;
        return e;
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [79:0] bytes, input int n);
        logic [AW-1:0] x;
        for (int i = 0; i < n; i++) begin
            x = a + AW'(i);
            mem[x[7:0]] = bytes[8 * i +: 8];
        end
    endtask

    // Issue one fetch; junk start pulses follow while busy and in the done cycle.
    task automatic issue(input logic [2:0] k, input logic [AW-1:0] a, input exp_t e);
        @(negedge clk);
        start = 1'b1; kind = k; start_addr = a;
        @(posedge clk);
        #1;
        e.issue = cyc;
        sb.push_back(e);
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int j = 0; j <= e.lat; j++) begin
            @(negedge clk);
            start = 1'($urandom); kind = 3'($urandom); start_addr = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic exp_t mk(input logic [63:0] v, input logic [AW-1:0] nx, input logic m,
                                input int l);
        exp_t e;
        e.value = v; e.next = nx; e.mal = m; e.lat = l; e.issue = 0;
        return e;
    endfunction

    initial begin
        logic [2:0]    k;
        logic [AW-1:0] a;
        logic [7:0]    b;
        logic [AW-1:0] x;
        int            n, lim;
        bit            over;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_value", value, 64'd0);
        chk("reset_next_addr", 64'(next_addr), 64'd0);
        chk("reset_rom_addr", 64'(rom_addr), 64'd0);
        chk("reset_malformed", 64'(malformed), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived expectations.
        load(32'd4, 80'h0000_C000000000000000, 8);
        issue(3'd1, 32'd4, mk(64'hC000000000000000, 32'd12, 1'b0, 9));
        load(32'd0, 80'h7F, 1);
        issue(3'd3, 32'd0, mk(64'h00000000FFFFFFFF, 32'd1, 1'b0, 2));
        load(32'd20, 80'h268EE5, 3);
        issue(3'd4, 32'd20, mk(64'd624485, 32'd23, 1'b0, 4));
        load(32'd40, 80'h7F80_8080808080808080, 10);
        issue(3'd5, 32'd40, mk(64'h8000000000000000, 32'd50, 1'b0, 11));
        load(32'd60, 80'h018080808080, 6);
        issue(3'd2, 32'd60, mk(64'd0, 32'd65, 1'b1, 6));
        issue(3'd6, 32'd100, mk(64'd0, 32'd100, 1'b1, 1));
        load(32'hFFFF_FFFE, 80'h44332211, 4);
        issue(3'd0, 32'hFFFF_FFFE, mk(64'h44332211, 32'd2, 1'b0, 5));

        // Reset while FIX64 is reading byte 3: everything clears, no done.
        load(32'd128, 80'h0807060504030201, 8);
        @(negedge clk);
        start = 1'b1; kind = 3'd1; start_addr = 32'd128;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_value", value, 64'd0);
        chk("midreset_next_addr", 64'(next_addr), 64'd0);
        chk("midreset_rom_addr", 64'(rom_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(3'd1, 32'd128, mk(64'h0807060504030201, 32'd136, 1'b0, 9));

        // Randomised fetches against the reference model.
        for (int t = 0; t < 60; t++) begin
            k = 3'($urandom_range(0, 7));
            a = $urandom;
            for (int i = 0; i < 12; i++) begin
                x = a + AW'(i);
                mem[x[7:0]] = 8'($urandom);
            end
            if (k >= 3'd2 && k <= 3'd5) begin
                lim  = (k < 3'd4) ? 5 : 10;
                over = ($urandom_range(0, 5) == 0);
                n    = over ? lim : $urandom_range(1, lim);
                for (int i = 0; i < n; i++) begin
                    x = a + AW'(i);
                    b = 8'($urandom);
                    b[7] = over || (i < n - 1);
                    mem[x[7:0]] = b;
                end
            end
            issue(k, a, model(k, a));
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_done: got %0d pending fetches expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
